// File: rtl/mips_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the multicycle MIPS data bus.
// Stores to the data register fill a small FIFO; the status register reports FIFO and overrun state.
module mips_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] ADDR_TX      = 32'h1001_0024,
  parameter logic [31:0] ADDR_STATUS  = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Adr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  output logic [31:0] RD,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        last_q;
  logic              overrun_q, overrun_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              sel_tx, sel_status, full, empty, baud_end;
  logic              push_req, push, pop;
  logic              unused_bits;

  assign sel_tx     = (Adr[31:2] == ADDR_TX[31:2]);
  assign sel_status = (Adr[31:2] == ADDR_STATUS[31:2]);
  assign full       = (count_q == CntFull);
  assign empty      = (count_q == '0);
  assign baud_end   = (baud_q == BaudLast);
  // The transmitter takes a byte either from idle or on the final stop-bit cycle (no idle gap).
  assign pop        = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_end));
  assign push_req   = MemWrite && sel_tx;
  assign push       = push_req && (!full || pop);
  assign count_d    = count_q + CntW'(push) - CntW'(pop);
  assign unused_bits = ^{Adr[1:0], WD[31:8]};

  always_comb begin
    overrun_d = overrun_q;
    if (MemWrite && sel_status && WD[3]) overrun_d = 1'b0;
    if (push_req && !push) overrun_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (pop) begin
            shift_d = fifo_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is computed from next state so tx_o comes straight from a flop.
    tx_d = 1'b1;
    if (state_d == StStart)     tx_d = 1'b0;
    else if (state_d == StData) tx_d = shift_d[0];
    busy_d = (count_d != '0) || (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        last_q   <= WD[7:0];
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= WD[7:0];
  end

  always_comb begin
    RD = '0;
    if (sel_status)  RD = {28'b0, overrun_q, full, empty, busy_q};
    else if (sel_tx) RD = {24'b0, last_q};
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mips_uart_tx.sv
// Bench for mips_uart_tx: records the serial line every cycle and compares it, plus the
// status register, against a byte-level schedule model of the FIFO and transmitter.
module tb_mips_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int WAVE_N = 65536;
  localparam logic [31:0] ADDR_TX     = 32'h1001_0024;
  localparam logic [31:0] ADDR_STATUS = 32'h1001_0028;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Adr = '0;
  logic [31:0] WD = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] RD;
  logic        tx_o;
  logic        busy_o;

  mips_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_TX     (ADDR_TX),
    .ADDR_STATUS (ADDR_STATUS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Adr     (Adr),
    .WD      (WD),
    .MemWrite(MemWrite),
    .RD      (RD),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // wave[t] holds tx_o as it stands after rising edge number t.
  logic wave [WAVE_N];
  always @(negedge clk) if (edge_n < WAVE_N) wave[edge_n] = tx_o;

  int n_chk = 0;
  int n_pass = 0;
  int seg0 = 0;

  // Bus log since the last reset: push edges/bytes and overrun-clear edges.
  int         st_e[$];
  logic [7:0] st_b[$];
  int         clr_e[$];
  // Model results.
  int         acc_e[$];
  int         drop_e[$];
  int         fr_s[$];
  logic [7:0] fr_b[$];
  int         mq_e[$];
  logic [7:0] mq_b[$];
  int         m_np;
  logic [7:0] m_last;

  // A queued byte starts its frame one edge after it was pushed, and no sooner than
  // one full frame after the previous start.
  function automatic int next_start();
    return (m_np > mq_e[0] + 1) ? m_np : mq_e[0] + 1;
  endfunction

  function automatic void model_pop();
    int p;
    p = next_start();
    fr_s.push_back(p);
    fr_b.push_back(mq_b[0]);
    mq_e.delete(0);
    mq_b.delete(0);
    m_np = p + FRAME;
  endfunction

  function automatic void model_run();
    fr_s.delete(); fr_b.delete(); acc_e.delete(); drop_e.delete();
    mq_e.delete(); mq_b.delete();
    m_np = 0;
    m_last = 8'h00;
    foreach (st_e[i]) begin
      while (mq_e.size() > 0 && next_start() < st_e[i]) model_pop();
      if (mq_e.size() == DEPTH && next_start() == st_e[i]) model_pop();
      if (mq_e.size() < DEPTH) begin
        mq_e.push_back(st_e[i]);
        mq_b.push_back(st_b[i]);
        acc_e.push_back(st_e[i]);
        m_last = st_b[i];
      end else begin
        drop_e.push_back(st_e[i]);
      end
    end
    while (mq_e.size() > 0) model_pop();
  endfunction

  function automatic logic [31:0] m_status(int t);
    int ld = -1;
    int lc = -1;
    int c = 0;
    logic busy;
    foreach (acc_e[i]) if (acc_e[i] <= t) c++;
    foreach (fr_s[i]) if (fr_s[i] <= t) c--;
    foreach (drop_e[i]) if (drop_e[i] <= t) ld = drop_e[i];
    foreach (clr_e[i]) if (clr_e[i] <= t) lc = clr_e[i];
    busy = (c > 0);
    foreach (fr_s[i]) if (fr_s[i] <= t && t < fr_s[i] + FRAME) busy = 1'b1;
    return {28'b0, (ld >= 0 && ld >= lc), (c == DEPTH), (c == 0), busy};
  endfunction

  function automatic int frame_errs(int k);
    int n = 0;
    int j;
    logic exp;
    for (int i = 0; i < FRAME; i++) begin
      j = i / CPB;
      exp = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : fr_b[k][j-1];
      if (wave[fr_s[k] + i] !== exp) n++;
    end
    return n;
  endfunction

  function automatic int idle_errs(int from, int to);
    int n = 0;
    logic in_frame;
    for (int t = from; t <= to; t++) begin
      in_frame = 1'b0;
      foreach (fr_s[k]) if (t >= fr_s[k] && t < fr_s[k] + FRAME) in_frame = 1'b1;
      if (!in_frame && wave[t] !== 1'b1) n++;
    end
    return n;
  endfunction

  task automatic wait_edge(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Adr = a;
    WD = d;
    MemWrite = 1'b1;
    if (a[31:2] == ADDR_TX[31:2]) begin
      st_e.push_back(edge_n + 1);
      st_b.push_back(d[7:0]);
    end else if (a[31:2] == ADDR_STATUS[31:2] && d[3]) begin
      clr_e.push_back(edge_n + 1);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    MemWrite = 1'b0;
    Adr = 32'h0;
    WD = 32'h0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    Adr = a;
    #1 d = RD;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    st_e.delete(); st_b.delete(); clr_e.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seg0 = edge_n + 1;
  endtask

  task automatic wait_done();
    model_run();
    if (fr_s.size() > 0) wait_edge(fr_s[fr_s.size() - 1] + FRAME + 20);
    else wait_edge(edge_n + 50);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seg0 = edge_n + 1;
    bus_write(ADDR_TX, 32'h0000_003C);
    bus_idle();
    wait_edge(st_e[0] + 6);
    n_chk++;
    if ({tx_o, busy_o} !== 2'b01) $display("FAIL reset_pre: tx/busy got %b, want 01", {tx_o, busy_o});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (tx_o !== 1'b1) $display("FAIL reset_tx: got %b, want 1", tx_o);
    else n_pass++;
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b, want 0", busy_o);
    else n_pass++;
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r !== 32'h0000_0002) $display("FAIL reset_status: got %h, want 00000002", r);
    else n_pass++;
    read_reg(32'h1001_0030, r);
    n_chk++;
    if (r !== 32'h0) $display("FAIL reset_other_addr: got %h, want 00000000", r);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    st_e.delete(); st_b.delete(); clr_e.delete();
    seg0 = edge_n + 1;
    repeat (40) @(negedge clk);
    model_run();
    n_chk++;
    if (idle_errs(seg0, edge_n - 1) !== 0) $display("FAIL reset_no_resume: %0d low samples, want 0", idle_errs(seg0, edge_n - 1));
    else n_pass++;
  endtask

  task automatic test_single();
    int s;
    int e;
    logic [31:0] r;
    do_reset();
    bus_write(ADDR_TX, 32'h0000_00A5);
    bus_idle();
    model_run();
    s = fr_s[0];
    wait_edge(s + FRAME - 1);
    n_chk++;
    if (busy_o !== 1'b1) $display("FAIL single_busy_stop: got %b, want 1", busy_o);
    else n_pass++;
    wait_edge(s + FRAME);
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL single_busy_after: got %b, want 0", busy_o);
    else n_pass++;
    wait_done();
    e = frame_errs(0);
    n_chk++;
    if (e !== 0) $display("FAIL single_frame: %0d bad samples, want 0", e);
    else n_pass++;
    e = idle_errs(seg0, edge_n - 1);
    n_chk++;
    if (e !== 0) $display("FAIL single_idle: %0d low samples outside frame, want 0", e);
    else n_pass++;
    read_reg(ADDR_TX, r);
    n_chk++;
    if (r !== 32'h0000_00A5) $display("FAIL single_rd_tx: got %h, want 000000a5", r);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s;
    int e;
    logic [31:0] r;
    do_reset();
    for (int i = 1; i <= 4; i++) bus_write(ADDR_TX, i);
    bus_idle();
    model_run();
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r !== m_status(edge_n)) $display("FAIL b2b_status: got %h, want %h", r, m_status(edge_n));
    else n_pass++;
    s = fr_s[0];
    wait_edge(s + 4 * FRAME - 1);
    n_chk++;
    if (busy_o !== 1'b1) $display("FAIL b2b_busy_end: got %b, want 1", busy_o);
    else n_pass++;
    wait_edge(s + 4 * FRAME);
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL b2b_busy_after: got %b, want 0", busy_o);
    else n_pass++;
    wait_done();
    foreach (fr_s[k]) begin
      e = frame_errs(k);
      n_chk++;
      if (e !== 0) $display("FAIL b2b_frame%0d: %0d bad samples, want 0", k, e);
      else n_pass++;
    end
    e = idle_errs(seg0, edge_n - 1);
    n_chk++;
    if (e !== 0) $display("FAIL b2b_idle: %0d low samples outside frames, want 0", e);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int e;
    logic [31:0] r;
    do_reset();
    bus_write(ADDR_TX, 32'h10);
    bus_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) bus_write(ADDR_TX, $urandom_range(0, 254));
    bus_write(ADDR_TX, 32'hFF);
    bus_idle();
    model_run();
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r[3] !== 1'b1) $display("FAIL ovr_set: bit3 got %b, want 1", r[3]);
    else n_pass++;
    n_chk++;
    if (r !== m_status(edge_n)) $display("FAIL ovr_status: got %h, want %h", r, m_status(edge_n));
    else n_pass++;
    bus_write(ADDR_STATUS, 32'h8);
    bus_idle();
    model_run();
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r[3] !== 1'b0) $display("FAIL ovr_clear: bit3 got %b, want 0", r[3]);
    else n_pass++;
    n_chk++;
    if (r !== m_status(edge_n)) $display("FAIL ovr_status_clr: got %h, want %h", r, m_status(edge_n));
    else n_pass++;
    wait_done();
    foreach (fr_s[k]) begin
      e = frame_errs(k);
      n_chk++;
      if (e !== 0) $display("FAIL ovr_frame%0d: %0d bad samples, want 0", k, e);
      else n_pass++;
    end
    e = idle_errs(seg0, edge_n - 1);
    n_chk++;
    if (e !== 0) $display("FAIL ovr_dropped_sent: %0d low samples outside frames, want 0", e);
    else n_pass++;
    read_reg(ADDR_TX, r);
    n_chk++;
    if (r !== {24'b0, m_last}) $display("FAIL ovr_rd_tx: got %h, want %h", r, {24'b0, m_last});
    else n_pass++;
  endtask

  task automatic test_collision();
    int s;
    int e;
    logic [31:0] r;
    logic [7:0] y;
    do_reset();
    bus_write(ADDR_TX, 32'h3A);
    bus_idle();
    model_run();
    s = fr_s[0];
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) bus_write(ADDR_TX, $urandom_range(0, 255));
    bus_idle();
    model_run();
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r !== m_status(edge_n)) $display("FAIL coll_full: got %h, want %h", r, m_status(edge_n));
    else n_pass++;
    // Land the push on the stop-bit edge that pops the FIFO head.
    y = 8'($urandom_range(0, 255));
    wait_edge(s + FRAME - 2);
    bus_write(ADDR_TX, {24'b0, y});
    bus_idle();
    model_run();
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r[3] !== 1'b0) $display("FAIL coll_no_overrun: bit3 got %b, want 0", r[3]);
    else n_pass++;
    n_chk++;
    if (r !== m_status(edge_n)) $display("FAIL coll_status: got %h, want %h", r, m_status(edge_n));
    else n_pass++;
    read_reg(ADDR_TX, r);
    n_chk++;
    if (r !== {24'b0, y}) $display("FAIL coll_rd_tx: got %h, want %h", r, {24'b0, y});
    else n_pass++;
    wait_done();
    foreach (fr_s[k]) begin
      e = frame_errs(k);
      n_chk++;
      if (e !== 0) $display("FAIL coll_frame%0d: %0d bad samples, want 0", k, e);
      else n_pass++;
    end
    e = idle_errs(seg0, edge_n - 1);
    n_chk++;
    if (e !== 0) $display("FAIL coll_idle: %0d low samples outside frames, want 0", e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int s;
    int e;
    logic [7:0] b;
    b = 8'h55;
    do_reset();
    bus_write(ADDR_TX, {24'b0, b});
    bus_idle();
    model_run();
    s = fr_s[0];
    wait_edge(s + CPB + 3 * CPB + 7);
    n_chk++;
    if (tx_o !== b[3]) $display("FAIL midrst_bit3: got %b, want %b", tx_o, b[3]);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (tx_o !== 1'b1) $display("FAIL midrst_tx: got %b, want 1", tx_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    st_e.delete(); st_b.delete(); clr_e.delete();
    seg0 = edge_n + 1;
    repeat (300) @(negedge clk);
    model_run();
    e = idle_errs(seg0, edge_n - 1);
    n_chk++;
    if (e !== 0) $display("FAIL midrst_no_start: %0d low samples, want 0", e);
    else n_pass++;
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL midrst_busy: got %b, want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int gap;
    int e;
    logic [31:0] r;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: a = ADDR_STATUS;
        1: a = 32'h1001_002C;
        default: a = ADDR_TX | 32'($urandom_range(0, 3));
      endcase
      bus_write(a, $urandom);
      gap = $urandom_range(0, 5);
      gap = (gap == 0) ? $urandom_range(100, 400) : gap - 1;
      if (gap > 0) begin
        bus_idle();
        model_run();
        read_reg(ADDR_STATUS, r);
        n_chk++;
        if (r !== m_status(edge_n)) $display("FAIL rand_status%0d: got %h, want %h", i, r, m_status(edge_n));
        else n_pass++;
        repeat (gap - 1) @(negedge clk);
      end
    end
    bus_idle();
    wait_done();
    foreach (fr_s[k]) begin
      e = frame_errs(k);
      n_chk++;
      if (e !== 0) $display("FAIL rand_frame%0d: %0d bad samples, want 0", k, e);
      else n_pass++;
    end
    e = idle_errs(seg0, edge_n - 1);
    n_chk++;
    if (e !== 0) $display("FAIL rand_idle: %0d low samples outside frames, want 0", e);
    else n_pass++;
    read_reg(ADDR_STATUS, r);
    n_chk++;
    if (r !== m_status(edge_n)) $display("FAIL rand_status_end: got %h, want %h", r, m_status(edge_n));
    else n_pass++;
    read_reg(ADDR_TX, r);
    n_chk++;
    if (r !== {24'b0, m_last}) $display("FAIL rand_rd_tx: got %h, want %h", r, {24'b0, m_last});
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_collision();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
